// File: rtl/vc_pop_arbiter.sv
// Weighted round-robin arbiter that drains four VC FIFOs into one downstream FIFO.
// Optional macro VC0_STRICT_PRIO_EN gives VC0 absolute priority without disturbing the round-robin.
module vc_pop_arbiter #(
    parameter int DATA_W = 12,
    parameter int W0     = 1,
    parameter int W1     = 1,
    parameter int W2     = 1,
    parameter int W3     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              empty_0,
    input  logic              empty_1,
    input  logic              empty_2,
    input  logic              empty_3,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [DATA_W-1:0] data_in_3,
    input  logic              almost_full_out,
    output logic              pop_0,
    output logic              pop_1,
    output logic              pop_2,
    output logic              pop_3,
    output logic              push,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        active_vc,
    output logic              idle
);

    // Weight 0 behaves as 1; anything above the 4-bit counter range is clamped.
    function automatic logic [3:0] eff_w(input int w);
        if (w <= 0)
            return 4'd1;
        else if (w > 15)
            return 4'd15;
        else
            return 4'(w);
    endfunction

    localparam logic [3:0] WE0 = eff_w(W0);
    localparam logic [3:0] WE1 = eff_w(W1);
    localparam logic [3:0] WE2 = eff_w(W2);
    localparam logic [3:0] WE3 = eff_w(W3);

    logic [1:0]        cur;
    logic [3:0]        burst_cnt;
    logic [3:0]        empty_v;
    logic [3:0]        wt_cur;
    logic              go;
    logic [1:0]        sel;
    logic [1:0]        idx;
    logic              sel_valid;
    logic              strict;
    logic [3:0]        pop_v;
    logic [DATA_W-1:0] data_sel;

    assign empty_v = {empty_3, empty_2, empty_1, empty_0};

    always_comb begin
        wt_cur = WE0;
        case (cur)
            2'd0:    wt_cur = WE0;
            2'd1:    wt_cur = WE1;
            2'd2:    wt_cur = WE2;
            default: wt_cur = WE3;
        endcase
    end

    always_comb begin
        go        = enable & ~almost_full_out & ~reset;
        sel       = cur;
        idx       = cur;
        sel_valid = 1'b0;
        strict    = 1'b0;
        if (!empty_v[cur] && (burst_cnt < wt_cur)) begin
            sel       = cur;
            sel_valid = 1'b1;
        end else begin
            // Search order cur+1, cur+2, cur+3, cur; i=4 wraps back to cur.
            for (int i = 1; i <= 4; i++) begin
                idx = cur + 2'(i);
                if (!sel_valid && !empty_v[idx]) begin
                    sel       = idx;
                    sel_valid = 1'b1;
                end
            end
        end
`ifdef VC0_STRICT_PRIO_EN
        if (!empty_v[0]) begin
            sel       = 2'd0;
            sel_valid = 1'b1;
            strict    = 1'b1;
        end
`endif
        pop_v = 4'b0000;
        if (go && sel_valid)
            pop_v[sel] = 1'b1;
    end

    always_comb begin
        data_sel = data_in_0;
        case (sel)
            2'd0:    data_sel = data_in_0;
            2'd1:    data_sel = data_in_1;
            2'd2:    data_sel = data_in_2;
            default: data_sel = data_in_3;
        endcase
    end

    assign pop_0 = pop_v[0];
    assign pop_1 = pop_v[1];
    assign pop_2 = pop_v[2];
    assign pop_3 = pop_v[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push      <= 1'b0;
            data_out  <= '0;
            cur       <= 2'd0;
            burst_cnt <= 4'd0;
        end else if (|pop_v) begin
            push     <= 1'b1;
            data_out <= data_sel;
            // Strict VC0 grants leave the round-robin position untouched.
            if (!strict) begin
                if (sel == cur) begin
                    burst_cnt <= (burst_cnt < wt_cur) ? burst_cnt + 4'd1 : 4'd1;
                end else begin
                    cur       <= sel;
                    burst_cnt <= 4'd1;
                end
            end
        end else begin
            push <= 1'b0;
        end
    end

    assign active_vc = cur;
    assign idle      = (&empty_v) & ~push;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Randomized and directed bench for vc_pop_arbiter against a queue-based reference model.
module tb_vc_pop_arbiter;

    localparam int DW = 12;
    localparam int WB [4] = '{3, 4, 1, 0};
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          almost_full_out = 1'b0;
    logic [3:0]    e = 4'hF;
    logic [DW-1:0] d [4];
    logic          pop_0, pop_1, pop_2, pop_3, push, idle;
    logic [DW-1:0] data_out;
    logic [1:0]    active_vc;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] mem [4][DEPTH];
    int hd [4];
    int cnt [4];

    int            m_cur;
    int            m_cnt;
    logic          m_push;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    vc_pop_arbiter #(.DATA_W(DW), .W0(WB[0]), .W1(WB[1]), .W2(WB[2]), .W3(WB[3])) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .empty_0(e[0]), .empty_1(e[1]), .empty_2(e[2]), .empty_3(e[3]),
        .data_in_0(d[0]), .data_in_1(d[1]), .data_in_2(d[2]), .data_in_3(d[3]),
        .almost_full_out(almost_full_out),
        .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
        .push(push), .data_out(data_out), .active_vc(active_vc), .idle(idle)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int weff(input int k);
        return (WB[k] == 0) ? 1 : WB[k];
    endfunction

    task automatic load(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            if (cnt[k] < DEPTH - 1) begin
                mem[k][(hd[k] + cnt[k]) % DEPTH] = DW'($urandom_range(0, 4095));
                cnt[k]++;
            end
        end
    endtask

    task automatic drive_fifos();
        for (int k = 0; k < 4; k++) begin
            e[k] = (cnt[k] == 0);
            d[k] = (cnt[k] == 0) ? DW'($urandom_range(0, 4095)) : mem[k][hd[k]];
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_cnt = 0; m_push = 1'b0; m_data = '0;
    endtask

    // One clock cycle: called just after a falling edge, returns just after the next one.
    task automatic cyc(input logic af, input logic en);
        int  sel;
        bit  strict;
        logic [3:0] exp_pop;
        almost_full_out = af;
        enable = en;
        drive_fifos();
        #1;
        sel = -1;
        strict = 0;
        if (en && !af) begin
            if (cnt[m_cur] > 0 && m_cnt < weff(m_cur))
                sel = m_cur;
            else
                for (int i = 1; i <= 4; i++)
                    if (sel < 0 && cnt[(m_cur + i) % 4] > 0)
                        sel = (m_cur + i) % 4;
`ifdef VC0_STRICT_PRIO_EN
            if (cnt[0] > 0) begin
                sel = 0;
                strict = 1;
            end
`endif
        end
        exp_pop = 4'b0000;
        if (sel >= 0) exp_pop[sel] = 1'b1;
        chk("pop", 16'({pop_3, pop_2, pop_1, pop_0}), 16'(exp_pop));
        chk("idle", 16'(idle), 16'((cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) && !m_push));
        @(posedge clk);
        #1;
        if (sel >= 0) begin
            m_push = 1'b1;
            m_data = mem[sel][hd[sel]];
            hd[sel] = (hd[sel] + 1) % DEPTH;
            cnt[sel]--;
            if (!strict) begin
                if (sel == m_cur)
                    m_cnt = (m_cnt < weff(m_cur)) ? m_cnt + 1 : 1;
                else begin
                    m_cur = sel;
                    m_cnt = 1;
                end
            end
        end else begin
            m_push = 1'b0;
        end
        chk("push", 16'(push), 16'(m_push));
        chk("data_out", 16'(data_out), 16'(m_data));
        chk("active_vc", 16'(active_vc), 16'(m_cur));
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            hd[k] = 0;
            cnt[k] = 0;
        end
        model_reset();

        // Reset state, with VC0 non-empty so pops must still be held off.
        load(0, 1);
        enable = 1'b1;
        drive_fifos();
        #1;
        chk("rst_pop", 16'({pop_3, pop_2, pop_1, pop_0}), 16'h0);
        chk("rst_push", 16'(push), 16'h0);
        chk("rst_data", 16'(data_out), 16'h0);
        chk("rst_vc", 16'(active_vc), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // VC0 (weight 3) against VC1 (weight 4), then VC1 drains alone.
        load(0, 5);
        load(1, 6);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1);

        // VC2 stream with a 4-cycle almost-full window.
        load(2, 8);
        for (int i = 0; i < 12; i++) cyc(i >= 3 && i < 7, 1'b1);

        // VC1 goes empty mid-burst; VC3 (weight 0 -> 1) takes over.
        load(1, 1);
        load(3, 3);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);

        // Enable drop together with almost-full: state must hold.
        load(0, 2);
        load(2, 2);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);

        // Random traffic and backpressure.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 3) == 0) load(k, $urandom_range(1, 3));
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) != 0);
        end

        // Asynchronous reset between clock edges with traffic in flight.
        for (int k = 0; k < 4; k++) load(k, 3);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        drive_fifos();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_pop", 16'({pop_3, pop_2, pop_1, pop_0}), 16'h0);
        chk("arst_push", 16'(push), 16'h0);
        chk("arst_data", 16'(data_out), 16'h0);
        chk("arst_vc", 16'(active_vc), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);

        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 4) == 0) load(k, $urandom_range(1, 4));
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
